// File: rtl/mm_addr_pkg.sv
// mm_addr_pkg
//   Shared types and helpers for the operand address generators.
//   - op_mode_e : which operand buffer is addressed (A row-tiled, B col-tiled)
//   - state_e   : sequencer state
//   - tile_count: number of tiles covering a dimension (ceil(dim / tile))
package mm_addr_pkg;

  typedef enum logic {
    OP_A = 1'b0,
    OP_B = 1'b1
  } op_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wide enough for any DIM_WIDTH up to 32 plus the carry of the round-up.
  localparam int TC_W = 33;

  // tile must be a power of two, so the division is a plain shift.
  function automatic logic [TC_W-1:0] tile_count(input logic [TC_W-1:0] dim,
                                                 input int unsigned tile);
    int unsigned sh;
    sh = $clog2(tile);
    return (dim + TC_W'(tile) - TC_W'(1)) >> sh;
  endfunction

endpackage

// File: rtl/nested_loop_counter.sv
// nested_loop_counter
//   Three-level index counter (outer / mid / inner, inner fastest).
//   Ports:
//     clk, reset_n            clock, async active-low reset
//     clear                   restart all indices at 0 (wins over advance)
//     advance                 step to the next index tuple
//     limit_outer/mid/inner   per-level trip counts (each >= 1 when used)
//     nxt_outer/mid/inner     index tuple that will be held after this edge
//     wrap_mid, wrap_inner    current mid / inner index is at its last value
//     last                    current tuple is the final one of the nest
module nested_loop_counter #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             advance,
  input  logic [CNT_W-1:0] limit_outer,
  input  logic [CNT_W-1:0] limit_mid,
  input  logic [CNT_W-1:0] limit_inner,
  output logic [CNT_W-1:0] nxt_outer,
  output logic [CNT_W-1:0] nxt_mid,
  output logic [CNT_W-1:0] nxt_inner,
  output logic             wrap_mid,
  output logic             wrap_inner,
  output logic             last
);

  logic [CNT_W-1:0] idx_outer, idx_mid, idx_inner;
  logic             wrap_outer;

  assign wrap_inner = (idx_inner == limit_inner - CNT_W'(1));
  assign wrap_mid   = (idx_mid   == limit_mid   - CNT_W'(1));
  assign wrap_outer = (idx_outer == limit_outer - CNT_W'(1));
  assign last       = wrap_inner && wrap_mid && wrap_outer;

  always_comb begin
    nxt_outer = idx_outer;
    nxt_mid   = idx_mid;
    nxt_inner = idx_inner;
    if (clear) begin
      nxt_outer = '0;
      nxt_mid   = '0;
      nxt_inner = '0;
    end else if (advance) begin
      if (!wrap_inner) begin
        nxt_inner = idx_inner + CNT_W'(1);
      end else begin
        nxt_inner = '0;
        if (!wrap_mid) begin
          nxt_mid = idx_mid + CNT_W'(1);
        end else begin
          nxt_mid   = '0;
          nxt_outer = wrap_outer ? '0 : idx_outer + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_outer <= '0;
      idx_mid   <= '0;
      idx_inner <= '0;
    end else begin
      idx_outer <= nxt_outer;
      idx_mid   <= nxt_mid;
      idx_inner <= nxt_inner;
    end
  end

endmodule

// File: rtl/operand_addr_generator.sv
// operand_addr_generator
//   Streams operand-buffer read addresses for a tiled matrix multiply.
//   Loop nest: row tile (outer), column tile (mid), k (inner).
//   Mode A address = base + rt*n + k, mode B address = base + ct*n + k,
//   built incrementally (no multiplier), wrapping modulo 2^AW.
//   Ports:
//     clk, reset_n                 clock, async active-low reset
//     start_i, abort_i             start request (IDLE only) / abort to IDLE
//     mode_i, m_i, n_i, p_i, base_i  job config, latched on start
//     addr_o, addr_valid_o, addr_ready_i  address stream with handshake
//     k_first_o, k_last_o          k == 0 / k == n-1 for the current address
//     tile_row_o, tile_col_o       current row / column tile index
//     row_partial_o, col_partial_o current tile is the ragged last one
//     busy_o, done_o               job in progress / one-cycle completion
module operand_addr_generator #(
  parameter int ARRAY_HEIGHT         = 4,
  parameter int ARRAY_WIDTH          = 4,
  parameter int BUFFER_ADDRESS_WIDTH = 10,
  parameter int DIM_WIDTH            = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic                            mode_i,
  input  logic [DIM_WIDTH-1:0]            m_i,
  input  logic [DIM_WIDTH-1:0]            n_i,
  input  logic [DIM_WIDTH-1:0]            p_i,
  input  logic [BUFFER_ADDRESS_WIDTH-1:0] base_i,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] addr_o,
  output logic                            addr_valid_o,
  input  logic                            addr_ready_i,
  output logic                            k_first_o,
  output logic                            k_last_o,
  output logic [DIM_WIDTH-1:0]            tile_row_o,
  output logic [DIM_WIDTH-1:0]            tile_col_o,
  output logic                            row_partial_o,
  output logic                            col_partial_o,
  output logic                            busy_o,
  output logic                            done_o
);
  import mm_addr_pkg::*;

  localparam int AW = BUFFER_ADDRESS_WIDTH;
  localparam int CW = DIM_WIDTH + 1;
  localparam logic [DIM_WIDTH-1:0] H_MASK = DIM_WIDTH'(ARRAY_HEIGHT - 1);
  localparam logic [DIM_WIDTH-1:0] W_MASK = DIM_WIDTH'(ARRAY_WIDTH - 1);

  state_e   state_q, state_d;

  op_mode_e             mode_q;
  logic [DIM_WIDTH-1:0] n_q;
  logic [CW-1:0]        rt_cnt_q, ct_cnt_q;
  logic                 row_part_q, col_part_q;
  logic [AW-1:0]        base_q, line_q;

  logic [CW-1:0] rt_cnt_in, ct_cnt_in;
  logic          row_part_in, col_part_in;
  logic          zero_dim, start_go, advance;
  logic [CW-1:0] nxt_outer, nxt_mid, nxt_inner;
  logic          wrap_mid, wrap_inner, cnt_last;
  logic [AW-1:0] n_step, line_next, addr_next;

  assign rt_cnt_in   = CW'(tile_count(TC_W'(m_i), ARRAY_HEIGHT));
  assign ct_cnt_in   = CW'(tile_count(TC_W'(p_i), ARRAY_WIDTH));
  assign row_part_in = (m_i & H_MASK) != '0;
  assign col_part_in = (p_i & W_MASK) != '0;
  assign zero_dim    = (m_i == '0) || (n_i == '0) || (p_i == '0);

  // Abort beats both start and the handshake.
  assign start_go = (state_q == IDLE) && start_i && !abort_i && !zero_dim;
  assign advance  = (state_q == RUN) && addr_valid_o && addr_ready_i &&
                    !abort_i && !cnt_last;
  assign n_step   = AW'(n_q);

  nested_loop_counter #(
    .CNT_W(CW)
  ) u_loops (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_go),
    .advance    (advance),
    .limit_outer(rt_cnt_q),
    .limit_mid  (ct_cnt_q),
    .limit_inner(CW'(n_q)),
    .nxt_outer  (nxt_outer),
    .nxt_mid    (nxt_mid),
    .nxt_inner  (nxt_inner),
    .wrap_mid   (wrap_mid),
    .wrap_inner (wrap_inner),
    .last       (cnt_last)
  );

  // line_q is the address of k == 0 for the current tile. In mode A it
  // moves on when the row tile changes and is revisited for each column
  // tile; in mode B it moves on per column tile and rewinds to base when
  // the row tile changes.
  always_comb begin
    line_next = line_q;
    addr_next = addr_o + AW'(1);
    if (wrap_inner) begin
      if (wrap_mid) begin
        line_next = (mode_q == OP_A) ? line_q + n_step : base_q;
      end else begin
        line_next = (mode_q == OP_A) ? line_q : line_q + n_step;
      end
      addr_next = line_next;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = zero_dim ? DONE : RUN;
      RUN:     if (addr_valid_o && addr_ready_i && cnt_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      addr_valid_o  <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      addr_o        <= '0;
      k_first_o     <= 1'b0;
      k_last_o      <= 1'b0;
      tile_row_o    <= '0;
      tile_col_o    <= '0;
      row_partial_o <= 1'b0;
      col_partial_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_valid_o <= (state_d == RUN);
      busy_o       <= (state_d != IDLE);
      done_o       <= (state_d == DONE);
      // First tuple comes straight from the inputs being latched this edge.
      if (start_go) begin
        addr_o        <= base_i;
        k_first_o     <= 1'b1;
        k_last_o      <= (n_i == DIM_WIDTH'(1));
        tile_row_o    <= '0;
        tile_col_o    <= '0;
        row_partial_o <= row_part_in && (rt_cnt_in == CW'(1));
        col_partial_o <= col_part_in && (ct_cnt_in == CW'(1));
      end else if (advance) begin
        addr_o        <= addr_next;
        k_first_o     <= (nxt_inner == '0);
        k_last_o      <= (nxt_inner == CW'(n_q) - CW'(1));
        tile_row_o    <= DIM_WIDTH'(nxt_outer);
        tile_col_o    <= DIM_WIDTH'(nxt_mid);
        row_partial_o <= row_part_q && (nxt_outer == rt_cnt_q - CW'(1));
        col_partial_o <= col_part_q && (nxt_mid == ct_cnt_q - CW'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_go) begin
      mode_q     <= op_mode_e'(mode_i);
      n_q        <= n_i;
      rt_cnt_q   <= rt_cnt_in;
      ct_cnt_q   <= ct_cnt_in;
      row_part_q <= row_part_in;
      col_part_q <= col_part_in;
      base_q     <= base_i;
      line_q     <= base_i;
    end else if (advance) begin
      line_q     <= line_next;
    end
  end

endmodule

// File: tb/tb_operand_addr_generator.sv
module tb_operand_addr_generator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i, abort_i, mode_i, addr_ready_i;
  logic [15:0] m_i, n_i, p_i;
  logic [9:0]  base_i;
  logic [9:0]  addr_o;
  logic        addr_valid_o, k_first_o, k_last_o;
  logic [15:0] tile_row_o, tile_col_o;
  logic        row_partial_o, col_partial_o, busy_o, done_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [9:0]  addr;
    logic        kf;
    logic        kl;
    logic [15:0] tr;
    logic [15:0] tc;
    logic        rp;
    logic        cp;
  } exp_t;

  typedef struct {
    bit mode;
    int m, n, p, base;
    bit rand_ready;
    bit pulse_start;
    int exp_count;
    int exp_last;
  } case_t;

  exp_t  q[$];
  case_t cases[9];

  always #5 clk = ~clk;

  operand_addr_generator #(
    .ARRAY_HEIGHT(4), .ARRAY_WIDTH(4), .BUFFER_ADDRESS_WIDTH(10), .DIM_WIDTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .abort_i(abort_i),
    .mode_i(mode_i), .m_i(m_i), .n_i(n_i), .p_i(p_i), .base_i(base_i),
    .addr_o(addr_o), .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
    .k_first_o(k_first_o), .k_last_o(k_last_o),
    .tile_row_o(tile_row_o), .tile_col_o(tile_col_o),
    .row_partial_o(row_partial_o), .col_partial_o(col_partial_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  function automatic logic [45:0] cur_pack();
    return {addr_o, k_first_o, k_last_o, tile_row_o, tile_col_o,
            row_partial_o, col_partial_o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference tuple sequence straight from the loop-nest definition.
  task automatic push_model(input case_t c);
    int rt_n, ct_n;
    exp_t e;
    rt_n = (c.m + 3) / 4;
    ct_n = (c.p + 3) / 4;
    for (int rt = 0; rt < rt_n; rt++)
      for (int ct = 0; ct < ct_n; ct++)
        for (int k = 0; k < c.n; k++) begin
          e.addr = 10'(c.base + (c.mode ? ct : rt) * c.n + k);
          e.kf   = (k == 0);
          e.kl   = (k == c.n - 1);
          e.tr   = 16'(rt);
          e.tc   = 16'(ct);
          e.rp   = (rt == rt_n - 1) && (c.m % 4 != 0);
          e.cp   = (ct == ct_n - 1) && (c.p % 4 != 0);
          q.push_back(e);
        end
  endtask

  task automatic apply_cfg(input case_t c);
    mode_i = c.mode;
    m_i    = 16'(c.m);
    n_i    = 16'(c.n);
    p_i    = 16'(c.p);
    base_i = 10'(c.base);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic run_case(input int idx, input case_t c);
    int   xfers, last_xfer, done_cyc, valid_cnt;
    logic prev_stall;
    logic [45:0] prev;
    logic [9:0]  last_addr;
    exp_t e;
    q.delete();
    push_model(c);
    apply_cfg(c);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    xfers = 0; last_xfer = -1; done_cyc = -1; valid_cnt = 0;
    prev_stall = 1'b0; prev = '0; last_addr = '0;
    check($sformatf("c%0d start_valid", idx), 64'(addr_valid_o), 64'(c.exp_count != 0));
    check($sformatf("c%0d start_busy", idx), 64'(busy_o), 64'(1));
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      if (prev_stall)
        check($sformatf("c%0d stall_hold", idx), 64'(cur_pack()), 64'(prev));
      if (addr_valid_o) valid_cnt++;
      if (c.pulse_start) begin
        start_i = (cyc == 4);
        m_i     = (cyc == 4) ? 16'd0 : 16'(c.m);
        mode_i  = (cyc == 4) ? ~c.mode : c.mode;
      end
      addr_ready_i = c.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (addr_valid_o && addr_ready_i) begin
        if (q.size() == 0) begin
          check($sformatf("c%0d extra_xfer", idx), 64'(xfers), 64'(c.exp_count));
        end else begin
          e = q.pop_front();
          check($sformatf("c%0d xfer%0d", idx, xfers), 64'(cur_pack()), 64'(e));
        end
        xfers++;
        last_xfer = cyc;
        last_addr = addr_o;
      end
      prev_stall = addr_valid_o && !addr_ready_i;
      prev = cur_pack();
      @(negedge clk);
    end
    apply_cfg(c);
    start_i = 1'b0;
    check($sformatf("c%0d done_seen", idx), 64'(done_cyc >= 0), 64'(1));
    if (done_cyc >= 0) begin
      check($sformatf("c%0d done_timing", idx), 64'(done_cyc),
            64'(c.exp_count == 0 ? 0 : last_xfer + 1));
      check($sformatf("c%0d done_valid", idx), 64'(addr_valid_o), 64'(0));
      check($sformatf("c%0d done_busy", idx), 64'(busy_o), 64'(1));
    end
    check($sformatf("c%0d xfer_count", idx), 64'(xfers), 64'(c.exp_count));
    if (c.exp_count == 0)
      check($sformatf("c%0d never_valid", idx), 64'(valid_cnt), 64'(0));
    else
      check($sformatf("c%0d last_addr", idx), 64'(last_addr), 64'(c.exp_last));
    @(negedge clk);
    check($sformatf("c%0d done_width", idx), 64'(done_o), 64'(0));
    check($sformatf("c%0d idle_busy", idx), 64'(busy_o), 64'(0));
  endtask

  initial begin
    //            mode  m  n  p  base  rnd   pulse cnt last
    cases[0] = '{1'b0, 8, 3, 8, 0,    1'b0, 1'b0, 12, 5};
    cases[1] = '{1'b1, 8, 3, 8, 100,  1'b0, 1'b0, 12, 105};
    cases[2] = '{1'b0, 6, 2, 5, 0,    1'b0, 1'b0, 8,  3};
    cases[3] = '{1'b0, 8, 3, 8, 0,    1'b1, 1'b0, 12, 5};
    cases[4] = '{1'b0, 0, 3, 8, 0,    1'b0, 1'b0, 0,  0};
    cases[5] = '{1'b0, 8, 3, 8, 0,    1'b0, 1'b1, 12, 5};
    cases[6] = '{1'b0, 4, 3, 4, 1022, 1'b0, 1'b0, 3,  0};
    cases[7] = '{1'b1, 5, 4, 9, 7,    1'b1, 1'b0, 24, 18};
    cases[8] = '{1'b0, 4, 1, 4, 0,    1'b0, 1'b0, 1,  0};

    reset_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; addr_ready_i = 1'b0;
    apply_cfg(cases[0]);
    repeat (2) @(negedge clk);
    check("reset outputs", 64'(cur_pack()), 64'(0));
    check("reset valid", 64'(addr_valid_o), 64'(0));
    check("reset busy_done", 64'({busy_o, done_o}), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_case(i, cases[i]);

    // Abort on the cycle that would take the 5th transfer.
    apply_cfg(cases[0]);
    addr_ready_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    check("abort pre_addr", 64'(addr_o), 64'(1));
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort valid", 64'(addr_valid_o), 64'(0));
    check("abort busy", 64'(busy_o), 64'(0));
    check("abort done", 64'(done_o), 64'(0));
    run_case(20, cases[0]);

    // Reset in the middle of a job.
    apply_cfg(cases[1]);
    addr_ready_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset outputs", 64'(cur_pack()), 64'(0));
    check("midreset ctrl", 64'({addr_valid_o, busy_o, done_o}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_case(21, cases[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_addr_generator.md
# operand_addr_generator

Parametrised successor to the A-operand address generator in the systolic matrix multiplier. It streams read addresses for either the A or the B operand buffer and supports dimensions that are not tile multiples, a programmable base address, valid/ready backpressure, abort, and per-address tile/k sideband for accumulator control. One instance sits between the config module and each operand buffer's read port.

## Interface
- ARRAY_HEIGHT, 4: PE rows (H); power of two ≥ 1.
- ARRAY_WIDTH, 4: PE columns (W); power of two ≥ 1.
- BUFFER_ADDRESS_WIDTH, 10: address width (AW).
- DIM_WIDTH, 16: width of m, n, p.
- clk  in  1  clock. One clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- abort_i  in  1  synchronous abort; returns to IDLE.
- mode_i  in  1  0 = A operand (row-tile indexed), 1 = B operand (col-tile indexed); latched on start.
- m_i, n_i, p_i  in  DIM_WIDTH each  matrix dims, A is m×n, B is n×p; latched on start.
- base_i  in  AW  buffer base address; latched on start.
- addr_o  out  AW  read address.
- addr_valid_o  out  1  addr_o and sideband valid.
- addr_ready_i  in  1  consumer accepts the current address.
- k_first_o, k_last_o  out  1 each  k == 0 / k == n−1 for the current address.
- tile_row_o, tile_col_o  out  DIM_WIDTH each  current row/column tile index.
- row_partial_o, col_partial_o  out  1 each  current tile is the last one and m mod H ≠ 0 / p mod W ≠ 0.
- busy_o  out  1  state ≠ IDLE.
- done_o  out  1  one-cycle completion pulse.

## Operation
- Tile counts: RT = (m + H−1) >> log2(H), CT = (p + W−1) >> log2(W). Compute at DIM_WIDTH+1 bits so there is no overflow.
- Loop nest, with k innermost: rt = 0..RT−1, then ct = 0..CT−1, then k = 0..n−1.
- Address: mode A gives base + rt·n + k. Mode B gives base + ct·n + k.
  - Compute incrementally: a row/col start register plus an inner offset. No multiplier.
  - Truncate to AW bits. Wrap modulo 2^AW is legal and must not be flagged.
- Total transfers = RT·CT·n.
- States:
  - IDLE: start_i → RUN, or → DONE if m, n or p is 0.
  - RUN: handshake of the last tuple → DONE.
  - DONE: unconditionally → IDLE after one cycle.
- abort_i from any state → IDLE. No done_o is produced, and addr_valid_o drops the next cycle.
- abort_i has priority over start_i and over the handshake.
- start_i outside IDLE is ignored, and so is a change of config inputs.
- Handshake: a transfer occurs on a cycle where addr_valid_o && addr_ready_i.
  - While valid && !ready, addr_o and all sideband outputs hold stable.
  - Valid never drops without a transfer, except on abort.

## Timing
- Reset values:
  - addr_o = 0 and addr_valid_o = 0.
  - k_first_o = 0, k_last_o = 0.
  - tile_row_o = 0, tile_col_o = 0.
  - row_partial_o = 0, col_partial_o = 0.
  - busy_o = 0, done_o = 0; state = IDLE.
- All outputs are registered.
- Start latency: start_i sampled at edge 0 → addr_valid_o = 1 with the first address (base) after edge 0. That is one cycle of latency.
- Throughput: one address per cycle while addr_ready_i is held 1.
- done_o is high for the single cycle after the edge that took the final transfer. addr_valid_o is 0 in that cycle.
- Zero-dim start: done_o is high in the cycle after start, with no valid ever asserted.
- busy_o is high from the cycle after start through the done_o cycle inclusive.
- A new start is accepted in the cycle after done_o.
- Reset asserted mid-run immediately forces the reset values above.

## Structure
- Package mm_addr_pkg:
  - typedef enum for operand mode (OP_A, OP_B).
  - typedef enum for state (IDLE, RUN, DONE).
  - function clog2-based tile_count().
- One sub-module, nested_loop_counter.
  - Three-level counter with per-level limits and an advance enable.
  - Outputs the indices, per-level wrap flags and a last flag.
  - The parent owns the address arithmetic, the handshake and the FSM.
- Target size is about 200–300 lines of RTL in total.

## Test plan
- H=W=4, mode A, m=8, n=3, p=8, base=0, ready=1 → addresses 0,1,2,0,1,2,3,4,5,3,4,5.
  - k_first on 0/3, k_last on 2/5.
  - done_o one cycle after the 12th transfer.
- Same dims, mode B, base=100 → 100,101,102,103,104,105,100,101,102,103,104,105.
  - tile_col_o toggles every 3 transfers.
- Mode A, m=6, n=2, p=5 → RT=2, CT=2, 8 transfers.
  - row_partial_o = 1 only while rt = 1.
  - col_partial_o = 1 only while ct = 1.
- Random addr_ready_i (50%) on the first case → identical address sequence.
  - Outputs stable during every stall.
  - done_o only after the 12th transfer.
- m=0 start → done_o in the next cycle, addr_valid_o never high.
  - start_i pulsed during RUN → ignored.
- abort_i at transfer 5 → IDLE next cycle, no done_o; an immediate restart begins again from base.
  - Separately, base=1022, AW=10 → addresses wrap 1022, 1023, 0.
  - Separately, reset_n low mid-run → all outputs at their reset values immediately.
